// File: rtl/sha256_core_if.sv
// Handshake bundle for sha256_core: message in, digest out, busy status.
// With SHA256_MIDSTATE_EN defined it also carries the midstate seed inputs.
interface sha256_core_if #(
   parameter int NUM_BLOCKS = 2
);
   logic                      in_valid;
   logic                      in_ready;
   logic [512*NUM_BLOCKS-1:0] message;
   logic                      out_valid;
   logic                      out_ready;
   logic [255:0]              digest;
   logic                      busy;
`ifdef SHA256_MIDSTATE_EN
   logic [255:0]              midstate;
   logic                      use_midstate;

   modport slave (
      input  in_valid, message, out_ready, midstate, use_midstate,
      output in_ready, out_valid, digest, busy
   );
   modport master (
      output in_valid, message, out_ready, midstate, use_midstate,
      input  in_ready, out_valid, digest, busy
   );
`else
   modport slave (
      input  in_valid, message, out_ready,
      output in_ready, out_valid, digest, busy
   );
   modport master (
      output in_valid, message, out_ready,
      input  in_ready, out_valid, digest, busy
   );
`endif
endinterface

// File: rtl/sha256_core.sv
// Iterative SHA-256 core: one round per cycle over NUM_BLOCKS pre-padded blocks.
// Optional feature macro: SHA256_MIDSTATE_EN (seed block 0 from an external midstate).
//
// state  | meaning
// IDLE   | waiting for a message, in_ready high
// LOAD   | fill schedule window from block k, copy H into a..h
// ROUND  | 64 compression rounds, t = 0..63
// UPDATE | fold working registers into H, next block or finish
// DONE   | digest held, out_valid high until consumed
module sha256_core #(
   parameter int NUM_BLOCKS = 2,
   parameter int DIGEST_W   = 256
) (
   input logic          clk,
   input logic          rst,
   sha256_core_if.slave bus
);
   if (DIGEST_W != 256) begin : g_bad_digest_w
      $error("sha256_core: DIGEST_W must be 256");
   end
   if (NUM_BLOCKS < 1 || NUM_BLOCKS > 4) begin : g_bad_num_blocks
      $error("sha256_core: NUM_BLOCKS must be 1..4");
   end

   localparam int MSG_W = 512*NUM_BLOCKS;
   localparam logic [1:0] K_LAST = 2'(NUM_BLOCKS-1);
   localparam logic [255:0] H_INIT =
      256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

   localparam logic [31:0] K_TAB [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROUND, S_UPDATE, S_DONE} state_t;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   state_t              state_q, state_d;
   logic [5:0]          t_q, t_d;
   logic [1:0]          k_q, k_d;
   logic [MSG_W-1:0]    msg_q, msg_d;
   logic [31:0]         h_q [8];
   logic [31:0]         h_d [8];
   logic [31:0]         wk_q [8];
   logic [31:0]         wk_d [8];
   logic [31:0]         w_q [16];
   logic [31:0]         w_d [16];
   logic [DIGEST_W-1:0] dig_q, dig_d;

   logic [31:0] w_next, t1, t2, ch, maj, s0_big, s1_big;
   logic [255:0] seed;

`ifdef SHA256_MIDSTATE_EN
   assign seed = bus.use_midstate ? bus.midstate : H_INIT;
`else
   assign seed = H_INIT;
`endif

   // Window always holds W[t..t+15]; the word shifted in is W[t+16].
   assign w_next = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
                 + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];

   assign s1_big = rotr(wk_q[4], 6) ^ rotr(wk_q[4], 11) ^ rotr(wk_q[4], 25);
   assign s0_big = rotr(wk_q[0], 2) ^ rotr(wk_q[0], 13) ^ rotr(wk_q[0], 22);
   assign ch     = (wk_q[4] & wk_q[5]) ^ (~wk_q[4] & wk_q[6]);
   assign maj    = (wk_q[0] & wk_q[1]) ^ (wk_q[0] & wk_q[2]) ^ (wk_q[1] & wk_q[2]);
   assign t1     = wk_q[7] + s1_big + ch + K_TAB[t_q] + w_q[0];
   assign t2     = s0_big + maj;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         t_q     <= '0;
         k_q     <= '0;
         msg_q   <= '0;
         h_q     <= '{default: '0};
         wk_q    <= '{default: '0};
         w_q     <= '{default: '0};
         dig_q   <= '0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         k_q     <= k_d;
         msg_q   <= msg_d;
         h_q     <= h_d;
         wk_q    <= wk_d;
         w_q     <= w_d;
         dig_q   <= dig_d;
      end
   end

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      k_d     = k_q;
      msg_d   = msg_q;
      h_d     = h_q;
      wk_d    = wk_q;
      w_d     = w_q;
      dig_d   = dig_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               msg_d = bus.message;
               for (int i = 0; i < 8; i++) h_d[i] = seed[255-32*i -: 32];
               k_d     = '0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            for (int i = 0; i < 16; i++)
               w_d[i] = msg_q[MSG_W-1 - 512*int'(k_q) - 32*i -: 32];
            wk_d    = h_q;
            t_d     = '0;
            state_d = S_ROUND;
         end
         S_ROUND: begin
            wk_d[7] = wk_q[6];
            wk_d[6] = wk_q[5];
            wk_d[5] = wk_q[4];
            wk_d[4] = wk_q[3] + t1;
            wk_d[3] = wk_q[2];
            wk_d[2] = wk_q[1];
            wk_d[1] = wk_q[0];
            wk_d[0] = t1 + t2;
            for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
            w_d[15] = w_next;
            t_d     = t_q + 6'd1;
            if (t_q == 6'd63) state_d = S_UPDATE;
         end
         S_UPDATE: begin
            for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + wk_q[i];
            if (k_q == K_LAST) begin
               for (int i = 0; i < 8; i++) dig_d[DIGEST_W-1-32*i -: 32] = h_d[i];
               state_d = S_DONE;
            end else begin
               k_d     = k_q + 2'd1;
               state_d = S_LOAD;
            end
         end
         S_DONE: begin
            if (bus.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.digest    = dig_q;
endmodule

// File: tb/tb_sha256_core.sv
// Self-checking bench for sha256_core: a 1-block and a 2-block instance checked
// against known vectors and a plain-arithmetic SHA-256 reference model.
module tb_sha256_core;
   localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

   localparam bit [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   logic clk, rst;
   int   checks = 0;
   int   failures = 0;
   logic watch2 = 1'b0;
   logic ov2_seen = 1'b0;
   logic [255:0] ms_val = '0;
   logic         ms_use = 1'b0;

   sha256_core_if #(.NUM_BLOCKS(1)) b1 ();
   sha256_core_if #(.NUM_BLOCKS(2)) b2 ();

   sha256_core #(.NUM_BLOCKS(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
   sha256_core #(.NUM_BLOCKS(2)) u_dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   always @(negedge clk) if (watch2 && b2.out_valid) ov2_seen <= 1'b1;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit [31:0] ror(input bit [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Textbook SHA-256 over nb left-aligned blocks starting from 'seed'.
   function automatic logic [255:0] sha_ref(input logic [1023:0] msg, input int nb, input logic [255:0] seed);
      bit [31:0] hv [8];
      bit [31:0] v [8];
      bit [31:0] w [64];
      bit [31:0] t1, t2;
      logic [255:0] r;
      for (int i = 0; i < 8; i++) hv[i] = seed[255-32*i -: 32];
      for (int b = 0; b < nb; b++) begin
         for (int j = 0; j < 16; j++) w[j] = msg[1023-512*b-32*j -: 32];
         for (int j = 16; j < 64; j++)
            w[j] = (ror(w[j-2],17) ^ ror(w[j-2],19) ^ (w[j-2] >> 10)) + w[j-7]
                 + (ror(w[j-15],7) ^ ror(w[j-15],18) ^ (w[j-15] >> 3)) + w[j-16];
         for (int i = 0; i < 8; i++) v[i] = hv[i];
         for (int j = 0; j < 64; j++) begin
            t1 = v[7] + (ror(v[4],6) ^ ror(v[4],11) ^ ror(v[4],25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[j] + w[j];
            t2 = (ror(v[0],2) ^ ror(v[0],13) ^ ror(v[0],22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
         end
         for (int i = 0; i < 8; i++) hv[i] = hv[i] + v[i];
      end
      for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hv[i];
      return r;
   endfunction

   function automatic logic [1023:0] rand_msg();
      logic [1023:0] m;
      for (int i = 0; i < 32; i++) m[1023-32*i -: 32] = $urandom();
      return m;
   endfunction

   function automatic logic get_ov(input int d);
      return (d == 1) ? b1.out_valid : b2.out_valid;
   endfunction
   function automatic logic get_ir(input int d);
      return (d == 1) ? b1.in_ready : b2.in_ready;
   endfunction
   function automatic logic get_busy(input int d);
      return (d == 1) ? b1.busy : b2.busy;
   endfunction
   function automatic logic [255:0] get_dg(input int d);
      return (d == 1) ? b1.digest : b2.digest;
   endfunction

   task automatic set_in(input int d, input logic v, input logic [1023:0] m);
      if (d == 1) begin
         b1.in_valid = v;
         b1.message  = m[1023:512];
`ifdef SHA256_MIDSTATE_EN
         b1.use_midstate = v ? ms_use : 1'($urandom());
         b1.midstate     = v ? ms_val : {8{$urandom()}};
`endif
      end else begin
         b2.in_valid = v;
         b2.message  = m;
      end
   endtask

   task automatic set_ordy(input int d, input logic v);
      if (d == 1) b1.out_ready = v;
      else        b2.out_ready = v;
   endtask

   task automatic wait_done(input int d, output int lat);
      lat = 0;
      while (!get_ov(d) && lat < 2000) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run_hash(input int d, input logic [1023:0] m, output logic [255:0] dg, output int lat);
      @(negedge clk);
      set_in(d, 1'b1, m);
      @(posedge clk);
      #1;
      set_in(d, 1'b0, rand_msg());
      wait_done(d, lat);
      dg = get_dg(d);
   endtask

   task automatic drain(input int d);
      @(negedge clk);
      set_ordy(d, 1'b1);
      @(posedge clk);
      #1;
      set_ordy(d, 1'b0);
      chk("drain_in_ready", {255'h0, get_ir(d)}, 256'd1);
      chk("drain_out_valid", {255'h0, get_ov(d)}, 256'd0);
   endtask

   logic [1023:0] m_abc, m_empty, m_two, m;
   logic [255:0]  dg, exp_dg;
   int            lat, n, d, nb;
   logic          seen_low;

   initial begin
      m_abc   = {32'h61626380, 448'h0, 32'h18, 512'h0};
      m_empty = {32'h80000000, 480'h0, 512'h0};
      m_two   = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000,
                 480'h0, 32'h000001c0};
      rst = 1'b0;
      set_in(1, 1'b0, '0);
      set_in(2, 1'b0, '0);
      set_ordy(1, 1'b0);
      set_ordy(2, 1'b0);
`ifdef SHA256_MIDSTATE_EN
      b2.use_midstate = 1'b0;
      b2.midstate     = '0;
`endif
      #12;
      for (int i = 1; i <= 2; i++) begin
         chk("rst_in_ready", {255'h0, get_ir(i)}, 256'd1);
         chk("rst_out_valid", {255'h0, get_ov(i)}, 256'd0);
         chk("rst_busy", {255'h0, get_busy(i)}, 256'd0);
         chk("rst_digest", get_dg(i), 256'd0);
      end
      @(negedge clk);
      rst = 1'b1;

      run_hash(1, m_abc, dg, lat);
      chk("abc_latency", 256'(lat), 256'd66);
      chk("abc_digest", dg, D_ABC);
      drain(1);

      run_hash(1, m_empty, dg, lat);
      chk("empty_digest", dg, D_EMPTY);
      drain(1);

      run_hash(2, m_two, dg, lat);
      chk("two_latency", 256'(lat), 256'd132);
      chk("two_digest", dg, D_TWO);
      drain(2);

      // Consumer stalls for 20 cycles in DONE.
      m = rand_msg();
      exp_dg = sha_ref(m, 1, IV);
      run_hash(1, m, dg, lat);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         chk("stall_out_valid", {255'h0, get_ov(1)}, 256'd1);
         chk("stall_digest", get_dg(1), exp_dg);
         chk("stall_in_ready", {255'h0, get_ir(1)}, 256'd0);
      end
      drain(1);

      for (int it = 0; it < 8; it++) begin
         d  = (it % 2) + 1;
         nb = d;
         m  = rand_msg();
         exp_dg = sha_ref(m, nb, IV);
         run_hash(d, m, dg, lat);
         chk("rand_latency", 256'(lat), 256'(66*nb));
         chk("rand_digest", dg, exp_dg);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         drain(d);
      end

      // Back-to-back with out_ready tied high.
      @(negedge clk);
      set_in(1, 1'b1, m_abc);
      set_ordy(1, 1'b1);
      @(posedge clk);
      #1;
      chk("tp_accept_busy", {255'h0, get_busy(1)}, 256'd1);
      n = 0;
      seen_low = 1'b0;
      while (n < 500) begin
         @(posedge clk);
         #1;
         n++;
         if (get_ov(1)) chk("tp_digest", get_dg(1), D_ABC);
         if (!get_busy(1)) seen_low = 1'b1;
         else if (seen_low) break;
      end
      chk("tp_period", 256'(n), 256'd68);
      @(negedge clk);
      set_in(1, 1'b0, rand_msg());
      wait_done(1, lat);
      chk("tp_second_digest", get_dg(1), D_ABC);
      set_ordy(1, 1'b0);
      drain(1);

      // Abort the 2-block instance at round 30 of block 1.
      @(negedge clk);
      set_in(2, 1'b1, rand_msg());
      @(posedge clk);
      #1;
      set_in(2, 1'b0, rand_msg());
      repeat (66 + 1 + 30) @(posedge clk);
      #1;
      rst = 1'b0;
      watch2 = 1'b1;
      #1;
      chk("abort_out_valid", {255'h0, get_ov(2)}, 256'd0);
      chk("abort_busy", {255'h0, get_busy(2)}, 256'd0);
      chk("abort_in_ready", {255'h0, get_ir(2)}, 256'd1);
      chk("abort_digest", get_dg(2), 256'd0);
      set_in(1, 1'b1, m_abc);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("first_edge_accept", {255'h0, get_busy(1)}, 256'd1);
      set_in(1, 1'b0, rand_msg());
      wait_done(1, lat);
      chk("post_rst_latency", 256'(lat), 256'd66);
      chk("post_rst_abc", get_dg(1), D_ABC);
      drain(1);
      repeat (80) @(posedge clk);
      watch2 = 1'b0;
      chk("abort_no_out_valid", {255'h0, ov2_seen}, 256'd0);
      run_hash(2, m_two, dg, lat);
      chk("post_rst_two", dg, D_TWO);
      drain(2);

`ifdef SHA256_MIDSTATE_EN
      ms_use = 1'b1;
      ms_val = IV;
      run_hash(1, m_abc, dg, lat);
      chk("mid_iv_abc", dg, D_ABC);
      drain(1);
      ms_val = {8{$urandom()}};
      for (int i = 0; i < 8; i++) ms_val[255-32*i -: 32] = $urandom();
      m = rand_msg();
      exp_dg = sha_ref(m, 1, ms_val);
      run_hash(1, m, dg, lat);
      chk("mid_rand", dg, exp_dg);
      drain(1);
      ms_use = 1'b0;
      run_hash(1, m_abc, dg, lat);
      chk("mid_off_abc", dg, D_ABC);
      drain(1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
